alu_md_seq: RTL and testbench

ALU_MD_SEQ -- requirements
Module: alu_md_seq

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_md_iter.sv | 102 ++++++++++
 rtl/alu_md_seq.sv | 126 ++++++++++++
 tb/tb_alu_md_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU with multiply/divide:
// opcode encoding, controller states and opcode classification helpers.
package alu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_XOR  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_SRA  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_MULH = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_DIVU = 4'b1101,
        OP_REM  = 4'b1110,
        OP_REMU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic is_mul_op(alu_op_e op);
        return op inside {OP_MUL, OP_MULH};
    endfunction

    function automatic logic is_div_op(alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(alu_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide engine: one shared {hi,lo} accumulator runs either
// radix-2 shift-add or restoring division on operand magnitudes, then sign-fixes.
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            run_i,
    input  logic            kill_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam int            CW   = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
    logic [XLEN-1:0]   opnd_q, opnd_d, ma, mb, half;
    logic [XLEN:0]     sum, rs, diff;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d;
    logic              signed_op, sa, sb;

    // Multiply: lo holds the multiplier, opnd the multiplicand.
    // Divide: lo holds the dividend (becomes quotient), hi the partial remainder.
    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff = rs - {1'b0, opnd_q};
        if (!is_div_q)
            acc_step = {sum, acc_q[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sel_hi_d  = sel_hi_q;
        neg_d     = neg_q;
        signed_op = is_mul_op(op_i) || is_signed_div(op_i);
        sa        = signed_op && a_i[XLEN-1];
        sb        = signed_op && b_i[XLEN-1];
        ma        = sa ? -a_i : a_i;
        mb        = sb ? -b_i : b_i;
        if (kill_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            is_div_d = is_div_op(op_i);
            acc_d    = {{XLEN{1'b0}}, (is_div_op(op_i) ? ma : mb)};
            opnd_d   = is_div_op(op_i) ? mb : ma;
            sel_hi_d = op_i inside {OP_MULH, OP_REM, OP_REMU};
            neg_d    = (op_i == OP_REM) ? sa : (sa ^ sb);
            cnt_d    = '0;
        end else if (run_i && cnt_q != LAST) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
        end
    end

    // Sign correction: the product negates as a whole, quotient/remainder per half.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        half     = sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (is_div_q)
            res_o = neg_q ? -half : half;
        else
            res_o = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        done_o = run_i && (cnt_q == LAST);
    end

endmodule

// File: rtl/alu_md_seq.sv
// Sequential ALU front end: single-cycle ops and divide special cases complete
// here; MUL/DIV families are handed to alu_md_iter under a valid/ready handshake.
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_MD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [OPC_W-1:0] alucontrol,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    localparam int              SHW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d, target;
    alu_op_e         op;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res, iter_res, result_q, result_d;
    logic            zero_q, zero_d, accept, div_zero, div_ovf, go_mul, go_div;
    logic            iter_run, iter_done;

    assign op       = alu_op_e'(alucontrol);
    assign shamt    = b[SHW-1:0];
    assign div_zero = (b == '0);
    assign div_ovf  = is_signed_div(op) && (a == XMIN) && (b == '1);
    assign go_mul   = ENABLE_MD && is_mul_op(op);
    assign go_div   = ENABLE_MD && is_div_op(op) && !div_zero && !div_ovf;
    assign target   = go_mul ? ST_MUL : (go_div ? ST_DIV : ST_DONE);
    assign accept   = in_valid && in_ready && !kill;
    assign iter_run = (state_q == ST_MUL) || (state_q == ST_DIV);

    // Divide-by-zero and signed overflow results double as the fast-path values.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_ADD:  alu_res = a + b;
            OP_AND:  alu_res = a & b;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_OR:   alu_res = a | b;
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            OP_DIV, OP_DIVU: if (ENABLE_MD) alu_res = div_zero ? '1 : a;
            OP_REM, OP_REMU: if (ENABLE_MD) alu_res = div_zero ? a : '0;
            default: alu_res = '0;
        endcase
    end

    alu_md_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept && (target != ST_DONE)),
        .run_i   (iter_run),
        .kill_i  (kill),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .done_o  (iter_done),
        .res_o   (iter_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:         if (accept) state_d = target;
            ST_MUL, ST_DIV:  if (iter_done) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)         state_d = target;
                else if (out_ready) state_d = ST_IDLE;
            end
            default:         state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    always_comb begin
        in_ready  = !reset && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        out_valid = (state_q == ST_DONE);
    end

    // The result register only changes on completion, so it holds through DONE.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        if (accept && target == ST_DONE) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
        end else if (iter_done && !kill) begin
            result_d = iter_res;
            zero_d   = (iter_res == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_md_seq.sv
// Self-checking bench for alu_md_seq (XLEN=32): directed vector table, random
// operations against an arithmetic reference model, and handshake corner cases.
module tb_alu_md_seq;

    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 1;
    localparam logic [XLEN-1:0] XMIN = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, kill, out_valid, out_ready, zero;
    logic [XLEN-1:0] a, b, result;
    logic [3:0]      alucontrol;
    logic            nm_in_valid, nm_in_ready, nm_out_valid, nm_zero;
    logic [XLEN-1:0] nm_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_md_seq #(.XLEN(XLEN), .ENABLE_MD(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alucontrol(alucontrol), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
    );

    alu_md_seq #(.XLEN(XLEN), .ENABLE_MD(1'b0)) dut_nomd (
        .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .a(a), .b(b), .alucontrol(alucontrol), .kill(kill),
        .out_valid(nm_out_valid), .out_ready(1'b1), .result(nm_result), .zero(nm_zero)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic [3:0] op, logic [31:0] av, logic [31:0] bv,
                                logic [31:0] res, logic z, int lat);
        vec_t v;
        v.op = op; v.a = av; v.b = bv; v.res = res; v.z = z; v.lat = 8'(lat);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written from the opcode definitions with plain arithmetic.
    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] av, logic [31:0] bv);
        int     sa, sb;
        longint p;
        int     sh;
        sa = int'(av);
        sb = int'(bv);
        sh = int'(bv % 32);
        p  = longint'(sa) * longint'(sb);
        case (op)
            4'd0:  return av ^ bv;
            4'd1:  return av << sh;
            4'd2:  return av + bv;
            4'd3:  return av & bv;
            4'd4:  return 32'(sa >>> sh);
            4'd5:  return av >> sh;
            4'd6:  return av - bv;
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return av | bv;
            4'd9:  return (av < bv) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (bv == 0) ? 32'hFFFF_FFFF : (av == XMIN && bv == 32'hFFFF_FFFF) ? av : 32'(sa / sb);
            4'd13: return (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            4'd14: return (bv == 0) ? av : (av == XMIN && bv == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: return (bv == 0) ? av : av % bv;
        endcase
    endfunction

    function automatic int ref_lat(logic [3:0] op, logic [31:0] av, logic [31:0] bv);
        if (op < 4'd10) return 0;
        if (op < 4'd12) return MD_LAT;
        if (bv == 0) return 0;
        if ((op == 4'd12 || op == 4'd14) && av == XMIN && bv == 32'hFFFF_FFFF) return 0;
        return MD_LAT;
    endfunction

    // Called #1 after a rising edge; returns edges counted after the accept edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic hold, output logic [31:0] r, output logic z, output int lat);
        int w;
        alucontrol = op; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        #1;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready before accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = !hold;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = result;
        z = zero;
    endtask

    initial begin : main
        logic [31:0] r, ea, eb, er;
        logic [3:0]  eop;
        logic        z, seen;
        int          lat;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; alucontrol = '0;
        kill = 1'b0; out_ready = 1'b1; nm_in_valid = 1'b0;

        vecs[0]  = mk(4'd2,  32'd1,          32'd2,          32'h3,          1'b0, 0);
        vecs[1]  = mk(4'd6,  32'd5,          32'd5,          32'h0,          1'b1, 0);
        vecs[2]  = mk(4'd4,  32'h8000_0000,  32'd1,          32'hC000_0000,  1'b0, 0);
        vecs[3]  = mk(4'd5,  32'h8000_0000,  32'd1,          32'h4000_0000,  1'b0, 0);
        vecs[4]  = mk(4'd1,  32'd1,          32'h21,         32'h2,          1'b0, 0);
        vecs[5]  = mk(4'd10, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, MD_LAT);
        vecs[6]  = mk(4'd11, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0, MD_LAT);
        vecs[7]  = mk(4'd12, 32'd7,          32'd0,          32'hFFFF_FFFF,  1'b0, 0);
        vecs[8]  = mk(4'd14, 32'd7,          32'd0,          32'h7,          1'b0, 0);
        vecs[9]  = mk(4'd12, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 0);
        vecs[10] = mk(4'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b1, 0);
        vecs[11] = mk(4'd12, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, MD_LAT);
        vecs[12] = mk(4'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, MD_LAT);
        vecs[13] = mk(4'd7,  32'hFFFF_FFFF,  32'd1,          32'h1,          1'b0, 0);
        vecs[14] = mk(4'd9,  32'hFFFF_FFFF,  32'd1,          32'h0,          1'b1, 0);
        vecs[15] = mk(4'd13, 32'd100,        32'd7,          32'd14,         1'b0, MD_LAT);
        vecs[16] = mk(4'd15, 32'd100,        32'd7,          32'd2,          1'b0, MD_LAT);
        vecs[17] = mk(4'd0,  32'hF0F0_1234,  32'h0F0F_1234,  32'hFFFF_0000,  1'b0, 0);
        vecs[18] = mk(4'd8,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 0);
        vecs[19] = mk(4'd3,  32'h0000_00F0,  32'h0000_000F,  32'h0,          1'b1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset zero", {63'd0, zero}, 64'd1);
        reset = 1'b0;
        #1;
        check("idle in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, z, lat);
            check($sformatf("vec%0d result", i), {32'd0, r}, {32'd0, vecs[i].res});
            check($sformatf("vec%0d zero", i), {63'd0, z}, {63'd0, vecs[i].z});
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            eop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       ea = XMIN;
                1:       ea = '0;
                default: ea = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       eb = '0;
                1:       eb = '1;
                2:       eb = 32'($urandom_range(1, 9));
                default: eb = $urandom;
            endcase
            er = ref_alu(eop, ea, eb);
            do_op(eop, ea, eb, 1'b0, r, z, lat);
            check($sformatf("rand%0d op%0d result", i, eop), {32'd0, r}, {32'd0, er});
            check($sformatf("rand%0d zero", i), {63'd0, z}, {63'd0, er == 0});
            check($sformatf("rand%0d latency", i), 64'(lat), 64'(ref_lat(eop, ea, eb)));
        end

        // Hold DONE with out_ready low, then accept a new op on the releasing edge.
        do_op(4'd12, 32'hFFFF_FFF9, 32'd2, 1'b1, r, z, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold result", {32'd0, result}, 64'hFFFF_FFFD);
            check("hold out_valid", {63'd0, out_valid}, 64'd1);
            check("hold in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        alucontrol = 4'd2; a = 32'd1; b = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b out_valid", {63'd0, out_valid}, 64'd1);
        check("b2b result", {32'd0, result}, 64'd3);
        @(posedge clk); #1;
        check("drain out_valid", {63'd0, out_valid}, 64'd0);

        // kill during DIVU iterations.
        alucontrol = 4'd13; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill out_valid", {63'd0, out_valid}, 64'd0);
        check("kill in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (MD_LAT + 5) begin @(posedge clk); #1; seen |= out_valid; end
        check("kill no late result", {63'd0, seen}, 64'd0);
        check("kill result untouched", {32'd0, result}, 64'd3);

        // kill wins over a same-cycle request.
        alucontrol = 4'd2; a = 32'd4; b = 32'd4; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill prio out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("kill prio out_valid2", {63'd0, out_valid}, 64'd0);
        check("kill prio result", {32'd0, result}, 64'd3);

        // Asynchronous reset in the middle of a MUL.
        alucontrol = 4'd10; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("async reset out_valid", {63'd0, out_valid}, 64'd0);
        check("async reset result", {32'd0, result}, 64'd0);
        check("async reset zero", {63'd0, zero}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (MD_LAT + 5) begin @(posedge clk); #1; seen |= out_valid; end
        check("reset discards op", {63'd0, seen}, 64'd0);
        check("reset then in_ready", {63'd0, in_ready}, 64'd1);

        // ENABLE_MD=0 instance: M-extension opcodes return zero in one cycle.
        alucontrol = 4'd10; a = 32'd3; b = 32'd5; nm_in_valid = 1'b1;
        @(posedge clk); #1;
        check("nomd MUL out_valid", {63'd0, nm_out_valid}, 64'd1);
        check("nomd MUL result", {32'd0, nm_result}, 64'd0);
        check("nomd MUL zero", {63'd0, nm_zero}, 64'd1);
        alucontrol = 4'd12; a = 32'd7; b = 32'd0;
        @(posedge clk); #1;
        check("nomd DIV result", {32'd0, nm_result}, 64'd0);
        alucontrol = 4'd2; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        nm_in_valid = 1'b0;
        check("nomd ADD result", {32'd0, nm_result}, 64'd3);
        check("nomd ADD out_valid", {63'd0, nm_out_valid}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
